// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with single-outstanding SRAM-like bus
//
// Purpose: owns the fetch PC and issues one instruction request at a time.
// It presents pc/inst/exception code to the IF/ID register, honours stalls,
// branch redirects and exception flushes, and swallows the responses of
// fetches that were cancelled while in flight.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   stall[3:0]               0 = IF/ID accepts the presented instruction
//   exception, exception_pc_i  flush request and its redirect target
//   branch_flag_i, branch_target_i  redirect applied when the stage advances
//   inst_req, inst_addr      bus request and word-aligned address
//   inst_addr_ok, inst_data_ok, inst_rdata  bus handshake and return data
//   pc_o, inst_o, exception_type_o, valid_o  presented fetch result
//   stall_req_o              fetch not complete, pipeline must stall
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
  parameter int          EXC_ADEL_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  stall,
  input  logic        exception,
  input  logic [31:0] exception_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] exception_type_o,
  output logic        valid_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [31:0] ADEL_CODE = 32'(1) << EXC_ADEL_BIT;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_adv_d;
  logic [31:0] pc_o_q;
  logic [31:0] inst_o_q;
  logic [31:0] exc_type_q;
  logic        valid_q;
  logic        aligned;

  assign aligned = (pc_q[1:0] == 2'b00);

  // A misaligned PC never reaches the bus; it turns into an AdEL result.
  assign inst_req    = (state_q == S_REQ) && aligned;
  assign inst_addr   = {pc_q[31:2], 2'b00};
  assign stall_req_o = (state_q != S_DONE);

  assign pc_o             = pc_o_q;
  assign inst_o           = inst_o_q;
  assign exception_type_o = exc_type_q;
  assign valid_o          = valid_q;

  always_comb begin
    pc_adv_d = pc_q + 32'd4;
    if (branch_flag_i) begin
      pc_adv_d = branch_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pc_o_q     <= '0;
      inst_o_q   <= '0;
      exc_type_q <= '0;
      valid_q    <= 1'b0;
    end else if (exception) begin
      pc_q       <= exception_pc_i;
      pc_o_q     <= '0;
      inst_o_q   <= '0;
      exc_type_q <= '0;
      valid_q    <= 1'b0;
      // If a request is (or just became) outstanding, its response must be
      // absorbed in S_DROP before the redirected fetch may be issued.
      case (state_q)
        S_REQ:   state_q <= (inst_req && inst_addr_ok) ? S_DROP : S_REQ;
        S_WAIT:  state_q <= inst_data_ok ? S_REQ : S_DROP;
        S_DONE:  state_q <= S_REQ;
        default: state_q <= inst_data_ok ? S_REQ : S_DROP;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (!aligned) begin
            pc_o_q     <= pc_q;
            inst_o_q   <= '0;
            exc_type_q <= ADEL_CODE;
            valid_q    <= 1'b1;
            state_q    <= S_DONE;
          end else if (inst_addr_ok) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            pc_o_q     <= pc_q;
            inst_o_q   <= inst_rdata;
            exc_type_q <= '0;
            valid_q    <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (stall == 4'b0000) begin
            pc_q    <= pc_adv_d;
            valid_q <= 1'b0;
            state_q <= S_REQ;
          end
        end
        default: begin
          if (inst_data_ok) begin
            state_q <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule
